// File: rtl/operand_fetch.sv
// operand_fetch: sits between the instruction fetcher and the execute stage.
// It picks up each new decoded instruction, obtains its operand (from the
// immediate byte, as a constant zero, or through a fixed-latency memory read)
// and hands opcode, operand and effective address to execute with a
// valid/ready handshake. A one-cycle done pulse then retires the instruction.
module operand_fetch #(
  parameter int REG_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 16,
  parameter int MEM_LATENCY = 1   // legal range 1..3
) (
  input  logic                  phi1,
  input  logic                  reset_n,
  input  logic                  instruction_ready,
  input  logic [REG_WIDTH-1:0]  instruction_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [REG_WIDTH-1:0]  imm_in,
  input  logic [REG_WIDTH-1:0]  mem_data,
  input  logic                  exec_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic [REG_WIDTH-1:0]  opcode_out,
  output logic [REG_WIDTH-1:0]  operand_out,
  output logic [ADDR_WIDTH-1:0] eff_addr_out,
  output logic                  operand_valid,
  output logic                  instruction_done,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, READ, PRESENT, DONE} state_t;

  // How the operand of an instruction is obtained.
  typedef enum logic [1:0] {CLS_NONE, CLS_IMM, CLS_STORE, CLS_READ} opclass_t;

  // READ ends on the cycle the counter reaches this value, so READ spans
  // exactly MEM_LATENCY cycles.
  localparam logic [1:0] LAST_CNT = 2'(MEM_LATENCY - 1);

  state_t                  state_q;
  opclass_t                class_q;
  logic                    ready_hist_q;
  logic [1:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic                    mem_rd_q;
  logic [REG_WIDTH-1:0]    opcode_q;
  logic [REG_WIDTH-1:0]    operand_q;
  logic [REG_WIDTH-1:0]    imm_q;
  logic [ADDR_WIDTH-1:0]   eff_addr_q;
  logic                    valid_q;
  logic                    done_q;
  logic                    busy_q;

  logic [7:0]              op_d;
  opclass_t                opclass_d;
  logic                    start_d;

  // Classification only looks at the low opcode byte.
  assign op_d    = instruction_in[7:0];

  // A start is a fresh rising edge of instruction_ready; a level held high
  // across instructions never restarts the block.
  assign start_d = instruction_ready & ~ready_hist_q;

  // Decode the operand class of the incoming opcode; immediate forms win
  // over the store group (e.g. 0x89, 0x80 are immediate).
  always_comb begin
    opclass_d = CLS_READ;
    if ((op_d[4:2] == 3'b010 && op_d[0]) ||
        (op_d[4:2] == 3'b000 && op_d[7] && !op_d[0])) begin
      opclass_d = CLS_IMM;
    end else if ((op_d[4:2] == 3'b010 && !op_d[0]) || (op_d[4:0] == 5'b11000)) begin
      opclass_d = CLS_NONE;
    end else if (op_d[7:5] == 3'b100) begin
      opclass_d = CLS_STORE;
    end
  end

  // Main sequencer: IDLE -> (READ) -> PRESENT -> DONE -> IDLE, all outputs registered.
  always_ff @(posedge phi1) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      class_q      <= CLS_NONE;
      ready_hist_q <= 1'b0;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      opcode_q     <= '0;
      operand_q    <= '0;
      imm_q        <= '0;
      eff_addr_q   <= '0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // History tracks the level in every state so edges seen while busy
      // are consumed and cannot fire later.
      ready_hist_q <= instruction_ready;
      case (state_q)
        IDLE: begin
          if (start_d) begin
            opcode_q   <= instruction_in;
            eff_addr_q <= addr_in;
            imm_q      <= imm_in;
            class_q    <= opclass_d;
            operand_q  <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            if (opclass_d == CLS_READ) begin
              // Memory address only moves when a read is launched.
              mem_rd_q   <= 1'b1;
              mem_addr_q <= addr_in;
              state_q    <= READ;
            end else begin
              valid_q    <= 1'b1;
              state_q    <= PRESENT;
            end
          end
        end
        READ: begin
          if (cnt_q == LAST_CNT) begin
            operand_q <= mem_data;
            mem_rd_q  <= 1'b0;
            valid_q   <= 1'b1;
            state_q   <= PRESENT;
          end else begin
            cnt_q     <= cnt_q + 2'd1;
          end
        end
        PRESENT: begin
          if (exec_ready) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr         = mem_addr_q;
  assign mem_rd           = mem_rd_q;
  assign opcode_out       = opcode_q;
  // Immediate operands come straight from the holding register; every other
  // class uses operand_q (memory data, or zero).
  assign operand_out      = (class_q == CLS_IMM) ? imm_q : operand_q;
  assign eff_addr_out     = eff_addr_q;
  assign operand_valid    = valid_q;
  assign instruction_done = done_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: one instance with MEM_LATENCY=1 (index 0) and one
// with MEM_LATENCY=3 (index 1), each with its own fixed-latency memory model.
`timescale 1ns/1ps
module tb_operand_fetch;

  logic        phi1 = 1'b0;
  logic        reset_n;
  int          cyc = 0;

  logic        instr_rdy [2];
  logic [7:0]  instr     [2];
  logic [15:0] addr      [2];
  logic [7:0]  imm       [2];
  logic [7:0]  mdata     [2];
  logic        exec_rdy  [2];
  logic [15:0] mem_addr  [2];
  logic        mem_rd    [2];
  logic [7:0]  opc_o     [2];
  logic [7:0]  opr_o     [2];
  logic [15:0] eff_o     [2];
  logic        valid_o   [2];
  logic        done_o    [2];
  logic        busy_o    [2];

  always #5 phi1 = ~phi1;
  always @(posedge phi1) cyc <= cyc + 1;

  operand_fetch #(.REG_WIDTH(8), .ADDR_WIDTH(16), .MEM_LATENCY(1)) u_dut_l1 (
    .phi1(phi1), .reset_n(reset_n), .instruction_ready(instr_rdy[0]),
    .instruction_in(instr[0]), .addr_in(addr[0]), .imm_in(imm[0]),
    .mem_data(mdata[0]), .exec_ready(exec_rdy[0]), .mem_addr(mem_addr[0]),
    .mem_rd(mem_rd[0]), .opcode_out(opc_o[0]), .operand_out(opr_o[0]),
    .eff_addr_out(eff_o[0]), .operand_valid(valid_o[0]),
    .instruction_done(done_o[0]), .busy(busy_o[0]));

  operand_fetch #(.REG_WIDTH(8), .ADDR_WIDTH(16), .MEM_LATENCY(3)) u_dut_l3 (
    .phi1(phi1), .reset_n(reset_n), .instruction_ready(instr_rdy[1]),
    .instruction_in(instr[1]), .addr_in(addr[1]), .imm_in(imm[1]),
    .mem_data(mdata[1]), .exec_ready(exec_rdy[1]), .mem_addr(mem_addr[1]),
    .mem_rd(mem_rd[1]), .opcode_out(opc_o[1]), .operand_out(opr_o[1]),
    .eff_addr_out(eff_o[1]), .operand_valid(valid_o[1]),
    .instruction_done(done_o[1]), .busy(busy_o[1]));

  // Memory model: data is valid only in the LATENCY-th consecutive mem_rd
  // cycle and only for the expected address; otherwise it returns EE.
  int          rd_run       [2];
  logic [7:0]  mem_val      [2];
  logic [15:0] mem_exp_addr [2];

  always @(posedge phi1) begin
    for (int k = 0; k < 2; k++) rd_run[k] <= (mem_rd[k] === 1'b1) ? rd_run[k] + 1 : 0;
  end
  assign mdata[0] = (mem_rd[0] === 1'b1 && rd_run[0] == 0 && mem_addr[0] == mem_exp_addr[0]) ? mem_val[0] : 8'hEE;
  assign mdata[1] = (mem_rd[1] === 1'b1 && rd_run[1] == 2 && mem_addr[1] == mem_exp_addr[1]) ? mem_val[1] : 8'hEE;

  // Monitor: counts valid/read/done cycles, captures each transfer payload.
  int          valid_cnt [2];
  int          rd_cnt    [2];
  int          done_cnt  [2];
  int          xfer_cnt  [2];
  int          unstable  [2];
  int          done_cyc  [2];
  logic [15:0] rd_addr   [2];
  logic [7:0]  x_op      [2];
  logic [7:0]  x_opr     [2];
  logic [15:0] x_eff     [2];
  logic        prev_valid[2];
  logic [31:0] prev_pay  [2];

  always @(negedge phi1) begin
    for (int k = 0; k < 2; k++) begin
      if (valid_o[k] === 1'b1) begin
        valid_cnt[k] <= valid_cnt[k] + 1;
        if (prev_valid[k] && prev_pay[k] !== {opc_o[k], opr_o[k], eff_o[k]})
          unstable[k] <= unstable[k] + 1;
        if (exec_rdy[k] === 1'b1) begin
          xfer_cnt[k] <= xfer_cnt[k] + 1;
          x_op[k]     <= opc_o[k];
          x_opr[k]    <= opr_o[k];
          x_eff[k]    <= eff_o[k];
        end
      end
      if (done_o[k] === 1'b1) begin
        done_cnt[k] <= done_cnt[k] + 1;
        done_cyc[k] <= cyc;
      end
      if (mem_rd[k] === 1'b1) begin
        rd_cnt[k]  <= rd_cnt[k] + 1;
        rd_addr[k] <= mem_addr[k];
      end
      prev_valid[k] <= (valid_o[k] === 1'b1);
      prev_pay[k]   <= {opc_o[k], opr_o[k], eff_o[k]};
    end
  end

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  opr;
    logic [15:0] eff;
  } exp_t;
  exp_t exp_q[$];

  int passed = 0;
  int total  = 0;

  // Drives one instruction (entered at posedge+1), pushes its expected
  // payload, waits for the done pulse, holding exec_ready low for 'stall'
  // PRESENT cycles. Returns at posedge+1 with the block idle again.
  task automatic drive_and_wait(input int k, input logic [7:0] op, input logic [15:0] a,
                                input logic [7:0] im, input logic [7:0] mv,
                                input logic [7:0] exp_opr, input int stall, input bit hold,
                                output bit timed_out, output int start_c);
    exp_t e;
    int   seen;
    bit   found;
    mem_val[k]      = mv;
    mem_exp_addr[k] = a;
    exec_rdy[k]     = (stall == 0);
    instr[k]        = op;
    addr[k]         = a;
    imm[k]          = im;
    instr_rdy[k]    = 1'b1;
    start_c         = cyc;
    e.op = op; e.opr = exp_opr; e.eff = a;
    exp_q.push_back(e);
    seen  = 0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge phi1);
      if (done_o[k] === 1'b1) begin
        found = 1'b1;
      end else if (valid_o[k] === 1'b1 && exec_rdy[k] === 1'b0) begin
        seen++;
        if (seen == stall) begin
          @(posedge phi1);
          #1 exec_rdy[k] = 1'b1;
        end
      end
    end
    timed_out = !found;
    if (!hold) instr_rdy[k] = 1'b0;
    exec_rdy[k] = 1'b1;
    repeat (2) @(posedge phi1);
    #1;
  endtask

  task automatic test_reset();
    logic [51:0] obs;
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      instr_rdy[k] = 1'b0; exec_rdy[k] = 1'b1; instr[k] = '0; addr[k] = '0;
      imm[k] = '0; mem_val[k] = '0; mem_exp_addr[k] = '0;
    end
    repeat (3) @(posedge phi1);
    @(negedge phi1);
    for (int k = 0; k < 2; k++) begin
      obs = {mem_addr[k], mem_rd[k], opc_o[k], opr_o[k], eff_o[k], valid_o[k], done_o[k], busy_o[k]};
      total++;
      if (obs !== 52'd0) $display("FAIL reset_outputs dut%0d: got %h expected 0", k, obs);
      else passed++;
    end
    @(posedge phi1); #1 reset_n = 1'b1;
    @(posedge phi1); #1;
  endtask

  task automatic test_imm();
    int b_rd = rd_cnt[0], b_v = valid_cnt[0], b_d = done_cnt[0], b_x = xfer_cnt[0];
    bit to; int sc; exp_t e;
    drive_and_wait(0, 8'hA9, 16'h0055, 8'h42, 8'h00, 8'h42, 0, 1'b0, to, sc);
    $display("imm A9: operand %h, done at +%0d", x_opr[0], done_cyc[0] - sc);
    total++; if (to) $display("FAIL imm_timeout: got no done expected done"); else passed++;
    e = exp_q.pop_front();
    total++; if (x_opr[0] !== e.opr) $display("FAIL imm_operand: got %h expected %h", x_opr[0], e.opr); else passed++;
    total++; if (x_op[0] !== e.op) $display("FAIL imm_opcode: got %h expected %h", x_op[0], e.op); else passed++;
    total++; if (x_eff[0] !== e.eff) $display("FAIL imm_eff: got %h expected %h", x_eff[0], e.eff); else passed++;
    total++; if (rd_cnt[0] - b_rd != 0) $display("FAIL imm_no_read: got %0d expected 0", rd_cnt[0] - b_rd); else passed++;
    total++; if (valid_cnt[0] - b_v != 1) $display("FAIL imm_valid_cycles: got %0d expected 1", valid_cnt[0] - b_v); else passed++;
    total++; if (xfer_cnt[0] - b_x != 1) $display("FAIL imm_transfers: got %0d expected 1", xfer_cnt[0] - b_x); else passed++;
    total++; if (done_cnt[0] - b_d != 1) $display("FAIL imm_done_count: got %0d expected 1", done_cnt[0] - b_d); else passed++;
    total++; if (done_cyc[0] - sc != 2) $display("FAIL imm_latency: got %0d expected 2", done_cyc[0] - sc); else passed++;
  endtask

  task automatic test_read_l1();
    int b_rd = rd_cnt[0];
    bit to; int sc; exp_t e;
    drive_and_wait(0, 8'hAD, 16'h1234, 8'h00, 8'h5A, 8'h5A, 0, 1'b0, to, sc);
    $display("read AD @1234: operand %h, done at +%0d", x_opr[0], done_cyc[0] - sc);
    total++; if (to) $display("FAIL rd1_timeout: got no done expected done"); else passed++;
    e = exp_q.pop_front();
    total++; if (x_opr[0] !== e.opr) $display("FAIL rd1_operand: got %h expected %h", x_opr[0], e.opr); else passed++;
    total++; if (rd_cnt[0] - b_rd != 1) $display("FAIL rd1_read_cycles: got %0d expected 1", rd_cnt[0] - b_rd); else passed++;
    total++; if (rd_addr[0] !== 16'h1234) $display("FAIL rd1_mem_addr: got %h expected 1234", rd_addr[0]); else passed++;
    total++; if (done_cyc[0] - sc != 3) $display("FAIL rd1_latency: got %0d expected 3", done_cyc[0] - sc); else passed++;
  endtask

  task automatic test_store();
    int b_rd = rd_cnt[0], b_d = done_cnt[0];
    bit to; int sc; exp_t e;
    drive_and_wait(0, 8'h8D, 16'h0200, 8'hFF, 8'h33, 8'h00, 0, 1'b0, to, sc);
    $display("store 8D @0200: operand %h eff %h", x_opr[0], x_eff[0]);
    e = exp_q.pop_front();
    total++; if (x_opr[0] !== e.opr) $display("FAIL st_operand: got %h expected %h", x_opr[0], e.opr); else passed++;
    total++; if (x_eff[0] !== e.eff) $display("FAIL st_eff: got %h expected %h", x_eff[0], e.eff); else passed++;
    total++; if (rd_cnt[0] - b_rd != 0) $display("FAIL st_no_read: got %0d expected 0", rd_cnt[0] - b_rd); else passed++;
    total++; if (done_cnt[0] - b_d != 1 || to) $display("FAIL st_done: got %0d expected 1", done_cnt[0] - b_d); else passed++;
    total++; if (mem_addr[0] !== 16'h1234) $display("FAIL st_mem_addr_hold: got %h expected 1234", mem_addr[0]); else passed++;
  endtask

  task automatic test_classes();
    // class codes: 0 IMM, 1 NONE, 2 STORE, 3 READ
    logic [7:0] ops [0:17];
    int         cls [0:17];
    int b_rd; bit to; int sc; exp_t e;
    logic [7:0] im, mv, eo; logic [15:0] a;
    ops = '{8'hA9, 8'hA0, 8'hC0, 8'hE0, 8'h69, 8'h89, 8'h80, 8'hAA, 8'h18,
            8'h38, 8'hE8, 8'h8D, 8'h85, 8'h81, 8'hAD, 8'h20, 8'hB5, 8'h7D};
    cls = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3};
    for (int i = 0; i < 18; i++) begin
      a  = 16'h3000 + 16'(i * 16'h0111);
      im = 8'h10 + 8'(i);
      mv = 8'hC0 + 8'(i);
      eo = (cls[i] == 0) ? im : (cls[i] == 3) ? mv : 8'h00;
      b_rd = rd_cnt[0];
      drive_and_wait(0, ops[i], a, im, mv, eo, 0, 1'b0, to, sc);
      $display("class op %h: operand %h eff %h done at +%0d", ops[i], x_opr[0], x_eff[0], done_cyc[0] - sc);
      e = exp_q.pop_front();
      total++; if (x_opr[0] !== e.opr || to) $display("FAIL cls_operand op %h: got %h expected %h", ops[i], x_opr[0], e.opr); else passed++;
      total++; if (x_eff[0] !== e.eff) $display("FAIL cls_eff op %h: got %h expected %h", ops[i], x_eff[0], e.eff); else passed++;
      total++; if (rd_cnt[0] - b_rd != ((cls[i] == 3) ? 1 : 0))
        $display("FAIL cls_read_cycles op %h: got %0d expected %0d", ops[i], rd_cnt[0] - b_rd, (cls[i] == 3) ? 1 : 0);
      else passed++;
      total++; if (done_cyc[0] - sc != ((cls[i] == 3) ? 3 : 2))
        $display("FAIL cls_latency op %h: got %0d expected %0d", ops[i], done_cyc[0] - sc, (cls[i] == 3) ? 3 : 2);
      else passed++;
    end
  endtask

  task automatic test_read_stall();
    int b_rd = rd_cnt[1], b_v = valid_cnt[1], b_d = done_cnt[1], b_u = unstable[1], b_x = xfer_cnt[1];
    bit to; int sc; exp_t e;
    drive_and_wait(1, 8'hB5, 16'h00A0, 8'h00, 8'h3C, 8'h3C, 4, 1'b0, to, sc);
    $display("stall B5 lat3: operand %h, valid %0d cycles, done at +%0d", x_opr[1], valid_cnt[1] - b_v, done_cyc[1] - sc);
    e = exp_q.pop_front();
    total++; if (x_opr[1] !== e.opr || to) $display("FAIL stall_operand: got %h expected %h", x_opr[1], e.opr); else passed++;
    total++; if (rd_cnt[1] - b_rd != 3) $display("FAIL stall_read_cycles: got %0d expected 3", rd_cnt[1] - b_rd); else passed++;
    total++; if (rd_addr[1] !== 16'h00A0) $display("FAIL stall_mem_addr: got %h expected 00a0", rd_addr[1]); else passed++;
    total++; if (valid_cnt[1] - b_v != 5) $display("FAIL stall_valid_cycles: got %0d expected 5", valid_cnt[1] - b_v); else passed++;
    total++; if (unstable[1] - b_u != 0) $display("FAIL stall_payload_stable: got %0d changes expected 0", unstable[1] - b_u); else passed++;
    total++; if (xfer_cnt[1] - b_x != 1) $display("FAIL stall_transfers: got %0d expected 1", xfer_cnt[1] - b_x); else passed++;
    total++; if (done_cnt[1] - b_d != 1) $display("FAIL stall_done_count: got %0d expected 1", done_cnt[1] - b_d); else passed++;
    total++; if (done_cyc[1] - sc != 9) $display("FAIL stall_latency: got %0d expected 9", done_cyc[1] - sc); else passed++;
  endtask

  task automatic test_reset_mid_read();
    int b_d = done_cnt[1], b_rd;
    bit to; int sc; exp_t e;
    logic [51:0] obs;
    mem_val[1] = 8'h77; mem_exp_addr[1] = 16'h4000;
    instr[1] = 8'hAD; addr[1] = 16'h4000; imm[1] = 8'h00; exec_rdy[1] = 1'b1;
    instr_rdy[1] = 1'b1;
    repeat (2) @(posedge phi1);
    #1 reset_n = 1'b0;          // second READ cycle
    @(negedge phi1);
    total++; if (mem_rd[1] !== 1'b1) $display("FAIL abort_in_read: got mem_rd %b expected 1", mem_rd[1]); else passed++;
    @(posedge phi1);
    @(negedge phi1);
    obs = {mem_addr[1], mem_rd[1], opc_o[1], opr_o[1], eff_o[1], valid_o[1], done_o[1], busy_o[1]};
    $display("reset mid-read: outputs %h", obs);
    total++; if (obs !== 52'd0) $display("FAIL abort_outputs: got %h expected 0", obs); else passed++;
    @(posedge phi1);
    #1 reset_n = 1'b1;          // instruction_ready still high: counts as a new edge
    total++; if (done_cnt[1] - b_d != 0) $display("FAIL abort_no_done: got %0d expected 0", done_cnt[1] - b_d); else passed++;
    b_rd = rd_cnt[1];
    drive_and_wait(1, 8'hB5, 16'h4100, 8'h00, 8'h99, 8'h99, 0, 1'b0, to, sc);
    $display("restart B5 @4100: operand %h, done at +%0d", x_opr[1], done_cyc[1] - sc);
    e = exp_q.pop_front();
    total++; if (x_opr[1] !== e.opr || to) $display("FAIL restart_operand: got %h expected %h", x_opr[1], e.opr); else passed++;
    total++; if (x_eff[1] !== e.eff) $display("FAIL restart_eff: got %h expected %h", x_eff[1], e.eff); else passed++;
    total++; if (rd_cnt[1] - b_rd != 3) $display("FAIL restart_read_cycles: got %0d expected 3", rd_cnt[1] - b_rd); else passed++;
    total++; if (done_cyc[1] - sc != 5) $display("FAIL restart_latency: got %0d expected 5", done_cyc[1] - sc); else passed++;
    total++; if (done_cnt[1] - b_d != 1) $display("FAIL restart_done_count: got %0d expected 1", done_cnt[1] - b_d); else passed++;
  endtask

  task automatic test_back_to_back();
    int b_d = done_cnt[0], b_x = xfer_cnt[0];
    bit to; int sc; exp_t e;
    drive_and_wait(0, 8'hA9, 16'h0010, 8'h11, 8'h00, 8'h11, 0, 1'b1, to, sc);
    instr[0] = 8'hA9; imm[0] = 8'h22; addr[0] = 16'h0020;   // ready never drops
    repeat (10) @(posedge phi1);
    #1;
    $display("held ready: transfers %0d done pulses %0d", xfer_cnt[0] - b_x, done_cnt[0] - b_d);
    e = exp_q.pop_front();
    total++; if (x_opr[0] !== e.opr || to) $display("FAIL b2b_operand: got %h expected %h", x_opr[0], e.opr); else passed++;
    total++; if (xfer_cnt[0] - b_x != 1) $display("FAIL b2b_transfers: got %0d expected 1", xfer_cnt[0] - b_x); else passed++;
    total++; if (done_cnt[0] - b_d != 1) $display("FAIL b2b_done_count: got %0d expected 1", done_cnt[0] - b_d); else passed++;
    total++; if (busy_o[0] !== 1'b0) $display("FAIL b2b_idle: got busy %b expected 0", busy_o[0]); else passed++;
    instr_rdy[0] = 1'b0;
    @(posedge phi1); #1;
  endtask

  initial begin
    test_reset();
    test_imm();
    test_read_l1();
    test_store();
    test_classes();
    test_read_stall();
    test_reset_mid_read();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected completion before 200us");
    $fatal(1, "watchdog expired");
  end

endmodule
